// File: rtl/fir_host.sv
// fir_host: AXI-Lite / AXI-Stream host that programs an FIR core, streams a ramp through it and
// polls ap_done. Define FIR_HOST_TIMEOUT_EN to give up after 1024 unsuccessful status reads.
module fir_host #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11,
  parameter int unsigned pDATA_LEN   = 600
) (
  input  logic                            axis_clk,
  input  logic                            axis_rst,
  input  logic                            start,
  input  logic [Tape_Num*pDATA_WIDTH-1:0] taps_flat,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic [pDATA_WIDTH-1:0]          checksum,
  output logic                            awvalid,
  output logic [pADDR_WIDTH-1:0]          awaddr,
  input  logic                            awready,
  output logic                            wvalid,
  output logic [pDATA_WIDTH-1:0]          wdata,
  input  logic                            wready,
  output logic                            arvalid,
  output logic [pADDR_WIDTH-1:0]          araddr,
  input  logic                            arready,
  input  logic                            rvalid,
  input  logic [pDATA_WIDTH-1:0]          rdata,
  output logic                            rready,
  output logic                            ss_tvalid,
  output logic [pDATA_WIDTH-1:0]          ss_tdata,
  output logic                            ss_tlast,
  input  logic                            ss_tready,
  input  logic                            sm_tvalid,
  input  logic [pDATA_WIDTH-1:0]          sm_tdata,
  input  logic                            sm_tlast,
  output logic                            sm_tready
);

  localparam int unsigned TapW = (Tape_Num > 1) ? $clog2(Tape_Num) : 1;
  localparam logic [31:0] Len  = 32'(pDATA_LEN);

  typedef enum logic [2:0] {
    StIdle, StWrLen, StWrTap, StWrStart, StStream, StPoll, StDone
  } state_e;

  state_e                   state_q;
  logic                     busy_q, done_q, err_q;
  logic [pDATA_WIDTH-1:0]   checksum_q;
  logic                     awvalid_q, wvalid_q, arvalid_q, rready_q;
  logic [pADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [pDATA_WIDTH-1:0]   wdata_q;
  logic                     wr_act_q, aw_ok_q, w_ok_q;
  logic [TapW-1:0]          tap_idx_q;
  logic                     ss_tvalid_q, ss_tlast_q, sm_tready_q;
  logic [pDATA_WIDTH-1:0]   ss_tdata_q;
  logic [31:0]              in_cnt_q, out_cnt_q;
`ifdef FIR_HOST_TIMEOUT_EN
  logic [10:0]              rd_cnt_q;
`endif

  logic                     aw_hs, w_hs, aw_ok_d, w_ok_d, wr_cmp, wr_state;
  logic                     ss_hs, sm_hs;
  logic [31:0]              in_cnt_d, out_cnt_d;
  logic [pADDR_WIDTH-1:0]   wr_addr;
  logic [pDATA_WIDTH-1:0]   wr_data;
  logic [pDATA_WIDTH-1:0]   tap_arr [Tape_Num];
  logic                     unused_rdata;

  for (genvar gi = 0; gi < Tape_Num; gi++) begin : g_tap
    assign tap_arr[gi] = taps_flat[gi*pDATA_WIDTH +: pDATA_WIDTH];
  end

  // Only the ap_done bit of the status register matters here.
  assign unused_rdata = ^{rdata[pDATA_WIDTH-1:2], rdata[0]};

  assign wr_state  = (state_q == StWrLen) || (state_q == StWrTap) || (state_q == StWrStart);
  assign aw_hs     = awvalid_q & awready;
  assign w_hs      = wvalid_q & wready;
  assign aw_ok_d   = aw_ok_q | aw_hs;
  assign w_ok_d    = w_ok_q | w_hs;
  assign wr_cmp    = wr_state & wr_act_q & aw_ok_d & w_ok_d;
  assign ss_hs     = ss_tvalid_q & ss_tready;
  assign sm_hs     = sm_tready_q & sm_tvalid;
  assign in_cnt_d  = in_cnt_q + 32'(ss_hs);
  assign out_cnt_d = out_cnt_q + 32'(sm_hs);

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    case (state_q)
      StWrLen: begin
        wr_addr = pADDR_WIDTH'(32'h10);
        wr_data = pDATA_WIDTH'(pDATA_LEN);
      end
      StWrTap: begin
        wr_addr = pADDR_WIDTH'(32'h20 + 32'(tap_idx_q) * 32'd4);
        wr_data = tap_arr[tap_idx_q];
      end
      StWrStart: begin
        wr_addr = '0;
        wr_data = pDATA_WIDTH'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      checksum_q  <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wr_act_q    <= 1'b0;
      aw_ok_q     <= 1'b0;
      w_ok_q      <= 1'b0;
      tap_idx_q   <= '0;
      ss_tvalid_q <= 1'b0;
      ss_tlast_q  <= 1'b0;
      ss_tdata_q  <= '0;
      sm_tready_q <= 1'b0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
`ifdef FIR_HOST_TIMEOUT_EN
      rd_cnt_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (aw_hs) awvalid_q <= 1'b0;
      if (w_hs)  wvalid_q  <= 1'b0;

      // Shared write engine: issue, then wait for both channels, then idle one cycle.
      if (wr_state) begin
        if (!wr_act_q) begin
          wr_act_q  <= 1'b1;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          awaddr_q  <= wr_addr;
          wdata_q   <= wr_data;
          aw_ok_q   <= 1'b0;
          w_ok_q    <= 1'b0;
        end else if (wr_cmp) begin
          wr_act_q <= 1'b0;
          aw_ok_q  <= 1'b0;
          w_ok_q   <= 1'b0;
        end else begin
          aw_ok_q <= aw_ok_d;
          w_ok_q  <= w_ok_d;
        end
      end

      case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StWrLen;
            busy_q     <= 1'b1;
            checksum_q <= '0;
            err_q      <= 1'b0;
            tap_idx_q  <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
          end
        end
        StWrLen: if (wr_cmp) state_q <= StWrTap;
        StWrTap: begin
          if (wr_cmp) begin
            if (tap_idx_q == TapW'(Tape_Num - 1)) state_q <= StWrStart;
            else tap_idx_q <= tap_idx_q + 1'b1;
          end
        end
        StWrStart: begin
          if (wr_cmp) begin
            state_q     <= StStream;
            ss_tvalid_q <= (Len != 32'd0);
            ss_tdata_q  <= '0;
            ss_tlast_q  <= (Len == 32'd1);
            sm_tready_q <= 1'b1;
          end
        end
        StStream: begin
          if (ss_hs) begin
            in_cnt_q <= in_cnt_d;
            if (in_cnt_d == Len) begin
              ss_tvalid_q <= 1'b0;
              ss_tlast_q  <= 1'b0;
            end else begin
              ss_tdata_q <= pDATA_WIDTH'(in_cnt_d);
              ss_tlast_q <= (in_cnt_d == Len - 32'd1);
            end
          end
          if (sm_hs) begin
            out_cnt_q  <= out_cnt_d;
            checksum_q <= checksum_q + sm_tdata;
            if (sm_tlast != (out_cnt_q == Len - 32'd1)) err_q <= 1'b1;
            if (out_cnt_d == Len) sm_tready_q <= 1'b0;
          end
          if (in_cnt_d == Len && out_cnt_d == Len) begin
            state_q     <= StPoll;
            sm_tready_q <= 1'b0;
            arvalid_q   <= 1'b1;
            araddr_q    <= '0;
            rready_q    <= 1'b1;
`ifdef FIR_HOST_TIMEOUT_EN
            rd_cnt_q    <= 11'd1;
`endif
          end
        end
        StPoll: begin
          if (arvalid_q && arready) arvalid_q <= 1'b0;
          if (rvalid && rready_q) begin
            if (rdata[1]) begin
              state_q  <= StDone;
              rready_q <= 1'b0;
              done_q   <= 1'b1;
            end
`ifdef FIR_HOST_TIMEOUT_EN
            else if (rd_cnt_q == 11'd1024) begin
              state_q  <= StDone;
              rready_q <= 1'b0;
              done_q   <= 1'b1;
              err_q    <= 1'b1;
            end
`endif
            else begin
              arvalid_q <= 1'b1;
`ifdef FIR_HOST_TIMEOUT_EN
              rd_cnt_q  <= rd_cnt_q + 11'd1;
`endif
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign checksum  = checksum_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign rready    = rready_q;
  assign ss_tvalid = ss_tvalid_q;
  assign ss_tdata  = ss_tdata_q;
  assign ss_tlast  = ss_tlast_q;
  assign sm_tready = sm_tready_q;

endmodule

// File: tb/tb_fir_host.sv
// tb_fir_host: randomized bench for fir_host with an ideal FIR slave and register model.
// Define FIR_HOST_TIMEOUT_EN to also run the poll-timeout scenario.
module tb_fir_host;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int NT  = 11;
  localparam int LEN = 600;

  logic              axis_clk = 1'b0;
  logic              axis_rst = 1'b1;
  logic              start = 1'b0;
  logic [NT*DW-1:0]  taps_flat;
  logic              busy, done, err;
  logic [DW-1:0]     checksum;
  logic              awvalid, wvalid, arvalid, rready;
  logic [AW-1:0]     awaddr, araddr;
  logic [DW-1:0]     wdata;
  logic              awready = 1'b0, wready = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [DW-1:0]     rdata = '0;
  logic              ss_tvalid, ss_tlast, sm_tready;
  logic [DW-1:0]     ss_tdata;
  logic              ss_tready = 1'b0, sm_tvalid = 1'b0, sm_tlast = 1'b0;
  logic [DW-1:0]     sm_tdata = '0;

  always #5 axis_clk = ~axis_clk;

  fir_host #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW), .Tape_Num(NT), .pDATA_LEN(LEN)) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .start(start), .taps_flat(taps_flat),
    .busy(busy), .done(done), .err(err), .checksum(checksum),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready),
    .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
  );

  int errors = 0;
  int checks = 0;

  // Scenario knobs, written only by the test tasks.
  bit aw_mode = 1'b0;
  bit ss_rand = 1'b0;
  bit never_done = 1'b0;
  int bad_last_idx = -1;

  // Slave-side observations, written only by the slave process.
  logic [AW-1:0] wr_addr_q [$];
  logic [DW-1:0] wr_data_q [$];
  logic [DW-1:0] ss_seen_d [$];
  logic          ss_seen_l [$];
  logic [DW-1:0] y_q [$];
  logic [DW-1:0] tap_reg [NT];
  int            n_out_sent, reads_seen, done_pulses, wr_pair, aw_wait;
  bit            w_got, ar_hs, r_hs, ss_hs, sm_hs;
  logic [DW-1:0] ss_d_cap;
  logic          ss_l_cap;

  function automatic logic [DW-1:0] fir_out(input int n);
    logic [DW-1:0] acc;
    acc = '0;
    for (int i = 0; i < NT && i <= n; i++) acc += tap_reg[i] * ss_seen_d[n-i];
    return acc;
  endfunction

  // Expected checksum straight from the definition: taps 0..NT-1, samples 0..LEN-1.
  function automatic logic [DW-1:0] golden_sum();
    logic [DW-1:0] s;
    s = '0;
    for (int n = 0; n < LEN; n++)
      for (int i = 0; i < NT && i <= n; i++) s += DW'(i) * DW'(n - i);
    return s;
  endfunction

  function automatic logic any_out();
    return |{busy, done, err, checksum, awvalid, awaddr, wvalid, wdata, arvalid, araddr,
             rready, ss_tvalid, ss_tdata, ss_tlast, sm_tready};
  endfunction

  // Bus slaves: commit the handshakes that completed at the last rising edge, then drive anew.
  always @(negedge axis_clk) begin
    if (axis_rst) begin
      awready = 1'b0; wready = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
      ss_tready = 1'b0; sm_tvalid = 1'b0; sm_tdata = '0; sm_tlast = 1'b0;
      wr_addr_q.delete(); wr_data_q.delete(); ss_seen_d.delete(); ss_seen_l.delete();
      y_q.delete();
      foreach (tap_reg[i]) tap_reg[i] = '0;
      n_out_sent = 0; reads_seen = 0; done_pulses = 0; wr_pair = 0; aw_wait = 0;
      w_got = 1'b0; ar_hs = 1'b0; r_hs = 1'b0; ss_hs = 1'b0; sm_hs = 1'b0;
    end else begin
      if (done) done_pulses++;
      if (r_hs) rvalid = 1'b0;
      if (ar_hs) begin
        rvalid = 1'b1;
        rdata  = (!never_done && n_out_sent == LEN) ? 32'h2 : 32'h0;
        reads_seen++;
      end
      if (ss_hs) begin
        ss_seen_d.push_back(ss_d_cap);
        ss_seen_l.push_back(ss_l_cap);
        y_q.push_back(fir_out(ss_seen_d.size() - 1));
      end
      if (sm_hs) begin
        void'(y_q.pop_front());
        n_out_sent++;
      end

      if (aw_wait > 0) aw_wait--;
      awready = aw_mode ? (awvalid && w_got && aw_wait == 0) : awvalid;
      if (awvalid && awready) begin
        wr_addr_q.push_back(awaddr);
        w_got = 1'b0;
      end
      wready = wvalid;
      if (wvalid && wready) begin
        wr_data_q.push_back(wdata);
        w_got   = 1'b1;
        aw_wait = 3;
      end
      while (wr_pair < wr_addr_q.size() && wr_pair < wr_data_q.size()) begin
        int a;
        a = int'(wr_addr_q[wr_pair]);
        if (a >= 'h20 && a < 'h20 + 4 * NT) tap_reg[(a - 'h20) / 4] = wr_data_q[wr_pair];
        wr_pair++;
      end

      arready = arvalid;
      ar_hs   = arvalid && arready;
      r_hs    = rvalid && rready;

      ss_tready = ss_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      ss_hs     = ss_tvalid && ss_tready;
      ss_d_cap  = ss_tdata;
      ss_l_cap  = ss_tlast;

      if (!sm_tvalid || sm_hs)
        sm_tvalid = (y_q.size() > 0) && (!ss_rand || $urandom_range(0, 3) != 0);
      sm_tdata = sm_tvalid ? y_q[0] : '0;
      sm_tlast = sm_tvalid && (n_out_sent == bad_last_idx || n_out_sent == LEN - 1);
      sm_hs    = sm_tvalid && sm_tready;
    end
  end

  task automatic pulse_reset();
    @(posedge axis_clk); #1;
    axis_rst = 1'b1;
    start    = 1'b0;
    repeat (2) @(posedge axis_clk);
    #1 axis_rst = 1'b0;
  endtask

  task automatic check_writes(input string name);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    checks++;
    if (wr_addr_q.size() != NT + 2 || wr_data_q.size() != NT + 2) begin
      errors++;
      $display("FAIL %s write_count addr=%0d data=%0d exp=%0d", name, wr_addr_q.size(),
               wr_data_q.size(), NT + 2);
    end
    for (int i = 0; i < NT + 2 && i < wr_addr_q.size() && i < wr_data_q.size(); i++) begin
      if (i == 0) begin
        ea = AW'('h10); ed = DW'(LEN);
      end else if (i <= NT) begin
        ea = AW'('h20 + 4 * (i - 1)); ed = DW'(i - 1);
      end else begin
        ea = '0; ed = DW'(1);
      end
      checks++;
      if (wr_addr_q[i] !== ea || wr_data_q[i] !== ed) begin
        errors++;
        $display("FAIL %s write[%0d] got addr=%h data=%0d exp addr=%h data=%0d", name, i,
                 wr_addr_q[i], wr_data_q[i], ea, ed);
      end
    end
  endtask

  task automatic check_samples(input string name);
    checks++;
    if (ss_seen_d.size() != LEN) begin
      errors++;
      $display("FAIL %s sample_count got=%0d exp=%0d", name, ss_seen_d.size(), LEN);
    end
    for (int n = 0; n < ss_seen_d.size(); n++) begin
      checks++;
      if (ss_seen_d[n] !== DW'(n) || ss_seen_l[n] !== 1'(n == LEN - 1)) begin
        errors++;
        $display("FAIL %s sample[%0d] got data=%0d last=%b exp data=%0d last=%b", name, n,
                 ss_seen_d[n], ss_seen_l[n], n, (n == LEN - 1));
      end
    end
  endtask

  task automatic run_and_check(input string name, input bit do_rst, input bit exp_err,
                               input bit poke_start);
    int cyc;
    if (do_rst) pulse_reset();
    @(posedge axis_clk); #1 start = 1'b1;
    @(posedge axis_clk); #1 start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_after_start got=%b exp=1", name, busy);
    end
    cyc = 0;
    while (done_pulses == 0 && cyc < 20000) begin
      @(posedge axis_clk); #1;
      cyc++;
      start = (poke_start && cyc == 300);
    end
    start = 1'b0;
    checks++;
    if (cyc >= 20000) begin
      errors++;
      $display("FAIL %s done_wait got=timeout exp=done", name);
    end
    repeat (4) @(posedge axis_clk);
    #1;
    checks++;
    if (done_pulses !== 1) begin
      errors++;
      $display("FAIL %s done_pulses got=%0d exp=1", name, done_pulses);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_done got=%b exp=0", name, busy);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err got=%b exp=%b", name, err, exp_err);
    end
    checks++;
    if (checksum !== golden_sum()) begin
      errors++;
      $display("FAIL %s checksum got=%h exp=%h", name, checksum, golden_sum());
    end
    checks++;
    if (n_out_sent != LEN) begin
      errors++;
      $display("FAIL %s outputs_taken got=%0d exp=%0d", name, n_out_sent, LEN);
    end
    check_writes(name);
    check_samples(name);
  endtask

  task automatic test_reset();
    axis_rst = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1;
    checks++;
    if (any_out() !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs got busy=%b done=%b err=%b cks=%h aw=%b w=%b ar=%b ss=%b sm=%b exp all 0",
               busy, done, err, checksum, awvalid, wvalid, arvalid, ss_tvalid, sm_tready);
    end
    axis_rst = 1'b0;
    repeat (3) @(posedge axis_clk);
    #1;
    checks++;
    if (any_out() !== 1'b0) begin
      errors++;
      $display("FAIL idle_without_start got busy=%b aw=%b exp quiet", busy, awvalid);
    end
  endtask

  task automatic test_basic();
    run_and_check("basic", 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_aw_delay();
    aw_mode = 1'b1;
    run_and_check("aw_delay", 1'b1, 1'b0, 1'b0);
    aw_mode = 1'b0;
  endtask

  task automatic test_ss_random();
    ss_rand = 1'b1;
    run_and_check("ss_random", 1'b1, 1'b0, 1'b0);
    ss_rand = 1'b0;
  endtask

  task automatic test_bad_last();
    bad_last_idx = 10;
    run_and_check("bad_last", 1'b1, 1'b1, 1'b0);
    bad_last_idx = -1;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit quiet;
    pulse_reset();
    @(posedge axis_clk); #1 start = 1'b1;
    @(posedge axis_clk); #1 start = 1'b0;
    cyc = 0;
    while (ss_seen_d.size() < 100 && cyc < 5000) begin
      @(posedge axis_clk); #1;
      cyc++;
    end
    checks++;
    if (cyc >= 5000) begin
      errors++;
      $display("FAIL reset_mid reach_n100 got=%0d samples exp=100", ss_seen_d.size());
    end
    axis_rst = 1'b1;
    @(posedge axis_clk); #1;
    checks++;
    if (any_out() !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs got busy=%b ss=%b sm=%b cks=%h exp all 0",
               busy, ss_tvalid, sm_tready, checksum);
    end
    axis_rst = 1'b0;
    quiet = 1'b1;
    repeat (20) begin
      @(posedge axis_clk); #1;
      if ((awvalid | wvalid | arvalid | ss_tvalid | sm_tready | busy) !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_mid_quiet got=activity exp=none");
    end
    run_and_check("rerun", 1'b0, 1'b0, 1'b0);
  endtask

`ifdef FIR_HOST_TIMEOUT_EN
  task automatic test_timeout();
    never_done = 1'b1;
    run_and_check("timeout", 1'b1, 1'b1, 1'b0);
    checks++;
    if (reads_seen != 1024) begin
      errors++;
      $display("FAIL timeout reads got=%0d exp=1024", reads_seen);
    end
    never_done = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < NT; i++) taps_flat[i*DW +: DW] = DW'(i);
    test_reset();
    test_basic();
    test_aw_delay();
    test_ss_random();
    test_bad_last();
    test_reset_mid();
`ifdef FIR_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_host.md
FIR_HOST -- requirements
Module: fir_host

Interface
REQ-001 SHALL have parameter pADDR_WIDTH, default 12, AXI-Lite address width.
REQ-002 SHALL have parameter pDATA_WIDTH, default 32, AXI-Lite and stream data width.
REQ-003 SHALL have parameter Tape_Num, default 11, number of FIR taps programmed.
REQ-004 SHALL have parameter pDATA_LEN, default 600, samples per run.
REQ-005 SHALL have ports:
 axis_clk  in  1  sole clock, rising edge
 axis_rst  in  1  synchronous, active-high reset
 start  in  1  one-cycle run request
 taps_flat  in  Tape_Num*pDATA_WIDTH  coefficients; tap i at bits [i*pDATA_WIDTH +: pDATA_WIDTH]
 busy  out  1  run in progress
 done  out  1  one-cycle run-complete pulse
 err  out  1  sticky error flag
 checksum  out  pDATA_WIDTH  wrapping sum of received outputs
 awvalid/awaddr  out  1/pADDR_WIDTH  write address
 awready  in  1
 wvalid/wdata  out  1/pDATA_WIDTH  write data
 wready  in  1
 arvalid/araddr  out  1/pADDR_WIDTH  read address
 arready  in  1
 rvalid/rdata  in  1/pDATA_WIDTH  read data
 rready  out  1
 ss_tvalid/ss_tdata/ss_tlast  out  1/pDATA_WIDTH/1  sample stream to FIR
 ss_tready  in  1
 sm_tvalid/sm_tdata/sm_tlast  in  1/pDATA_WIDTH/1  result stream from FIR
 sm_tready  out  1

Function
REQ-006 SHALL implement FSM IDLE -> WR_LEN -> WR_TAP -> WR_START -> STREAM -> POLL -> DONE -> IDLE.
REQ-007 IDLE: start=1 SHALL enter WR_LEN, set busy, clear checksum and err next cycle; start while busy SHALL be ignored.
REQ-008 Each write SHALL raise awvalid and wvalid together; each dropped independently the cycle after its ready handshake; write complete when both handshaken; next write issued no earlier than the following cycle.
REQ-009 WR_LEN SHALL write pDATA_LEN to 0x10; WR_TAP SHALL write tap i to 0x20+4*i for i=0..Tape_Num-1 in order; WR_START SHALL write 1 to 0x00.
REQ-010 STREAM: ss_tvalid=1 while samples remain; ss_tdata=sample index n (0..pDATA_LEN-1); ss_tlast=1 only for n=pDATA_LEN-1; n advances only on ss_tvalid&&ss_tready; data/last stable while stalled.
REQ-011 STREAM: sm_tready=1; each sm_tvalid&&sm_tready SHALL add sm_tdata to checksum modulo 2^pDATA_WIDTH and increment output count.
REQ-012 sm_tlast asserted on any output other than output pDATA_LEN-1, or absent on it, SHALL set err.
REQ-013 STREAM SHALL exit to POLL once all samples sent and pDATA_LEN outputs received, in either order; further sm beats outside STREAM SHALL not be accepted (sm_tready=0).
REQ-014 POLL: arvalid=1, araddr=0x00 until arready; rready=1; on rvalid with rdata[1]=1 go DONE, else re-issue read next cycle.
REQ-015 DONE: done=1 for exactly one cycle, busy=0 from next cycle, return to IDLE; checksum and err held until next start.
REQ-016 Simultaneous input and output handshakes in one cycle SHALL both be honoured.

Reset
REQ-017 axis_rst=1 at a clock edge SHALL force IDLE; busy, done, err, all valid/ready outputs, checksum, counters = 0; addresses/data = 0.
REQ-018 Reset mid-run SHALL abandon the run with no further bus activity until a new start.

Configuration
REQ-019 With FIR_HOST_TIMEOUT_EN defined, POLL SHALL count issued reads; at 1024 reads without ap_done SHALL set err and go DONE; without macro, POLL waits indefinitely.

Verification
REQ-020 Taps 0..10, ideal FIR slave, start -> 13 writes (0x10=600, 0x20..0x48=0..10, 0x00=1), 600 samples 0..599, done once, err=0, checksum matches golden.
REQ-021 awready 3 cycles after wready on every write -> each write completes once, no address/data duplicated or skipped.
REQ-022 ss_tready toggled randomly -> ss_tdata sequence exactly 0..599, ss_tlast only on 599.
REQ-023 Slave sm_tlast on output 10 -> err=1, run still completes with done pulse.
REQ-024 axis_rst pulsed during STREAM at n=100 -> all outputs 0 next cycle; new start reruns full sequence from WR_LEN.
REQ-025 FIR_HOST_TIMEOUT_EN, rdata[1] always 0 -> err=1 and done after 1024 reads.
